// File: rtl/alu_unit.sv
// ----------------------------------------------------------------------------
// alu_unit: RV32I integer ALU with one registered output stage.
//
// Decodes the instruction word, computes the result of an OP, OP-IMM, LUI or
// AUIPC instruction, and registers the result.
// All other opcodes, and unsupported funct3/funct7 combinations, are ignored.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   instr       in   RV32I instruction word
//   op1         in   rs1 value (PC of the instruction for AUIPC)
//   op2         in   rs2 value, only read by OP instructions
//   enable      in   instruction valid this cycle
//   instr_exec  out  one-cycle pulse: result holds a freshly computed value
//   result      out  registered ALU result
//
// Handshake: enable is a valid qualifier with no ready side. Every edge where
// enable=1 and the instruction is a supported ALU op produces instr_exec=1
// and a new result after that same edge. On any other edge instr_exec=0 and
// result keeps its previous value. There is no backpressure.
// ----------------------------------------------------------------------------
module alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            enable,
  output logic            instr_exec,
  output logic [XLEN-1:0] result
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic            f7_alt;
  logic            f7_base;
  logic [XLEN-1:0] alu_out;
  logic            op_ok;
  logic            opimm_ok;
  logic            supported;
  logic [XLEN-1:0] result_d;
  logic            exec_d;
  logic [XLEN-1:0] result_q;
  logic            exec_q;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign f7_alt  = (funct7 == F7_ALT);
  assign f7_base = (funct7 == F7_BASE);

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'h000};

  // Second operand: rs2 for register-register ops, I-immediate otherwise.
  // For shift-immediates the low 5 bits of imm_i are instr[24:20] (shamt).
  assign op_b  = (opcode == OPC_OP) ? op2 : imm_i;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_out = '0;
    case (funct3)
      3'b000: alu_out = ((opcode == OPC_OP) && f7_alt) ? (op1 - op_b) : (op1 + op_b);
      3'b001: alu_out = op1 << shamt;
      3'b010: alu_out = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op_b))};
      3'b011: alu_out = {{(XLEN-1){1'b0}}, (op1 < op_b)};
      3'b100: alu_out = op1 ^ op_b;
      3'b101: alu_out = f7_alt ? XLEN'($signed(op1) >>> shamt) : (op1 >> shamt);
      3'b110: alu_out = op1 | op_b;
      3'b111: alu_out = op1 & op_b;
      default: alu_out = '0;
    endcase
  end

  // funct7 legality. For OP the alternate encoding only exists for SUB/SRA.
  // For OP-IMM funct7 is part of the immediate except on the shift encodings.
  always_comb begin
    op_ok = f7_base || (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    case (funct3)
      3'b001:  opimm_ok = f7_base;
      3'b101:  opimm_ok = f7_base || f7_alt;
      default: opimm_ok = 1'b1;
    endcase
  end

  always_comb begin
    supported = 1'b0;
    result_d  = alu_out;
    case (opcode)
      OPC_OP:    supported = op_ok;
      OPC_OPIMM: supported = opimm_ok;
      OPC_LUI: begin
        supported = 1'b1;
        result_d  = imm_u;
      end
      OPC_AUIPC: begin
        supported = 1'b1;
        result_d  = op1 + imm_u;
      end
      default:   supported = 1'b0;
    endcase
  end

  assign exec_d = enable && supported;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      exec_q   <= 1'b0;
    end else begin
      exec_q <= exec_d;
      if (exec_d) begin
        result_q <= result_d;
      end
    end
  end

  assign instr_exec = exec_q;
  assign result     = result_q;

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        enable;
  logic        instr_exec;
  logic [31:0] result;

  int n_checks;
  int n_errors;

  // Each entry: {expected instr_exec, expected result}
  logic [32:0] exp_q[$];
  logic [31:0] last_res;

  alu_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .op1        (op1),
    .op2        (op2),
    .enable     (enable),
    .instr_exec (instr_exec),
    .result     (result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [6:0] opc);
    return {imm, 5'd3, opc};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [32:0] model(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b2, input logic [31:0] prev);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] b;
    logic        is_reg;
    logic        ok;
    logic [31:0] r;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    r   = 32'h0;
    ok  = 1'b0;
    if (opc == 7'b0110111) return {1'b1, ins[31:12], 12'h000};
    if (opc == 7'b0010111) return {1'b1, a + {ins[31:12], 12'h000}};
    if (opc != 7'b0110011 && opc != 7'b0010011) return {1'b0, prev};
    is_reg = (opc == 7'b0110011);
    b = is_reg ? b2 : {{20{ins[31]}}, ins[31:20]};
    case (f3)
      3'd0: begin
        if (is_reg && f7 == 7'h20) begin r = a - b; ok = 1'b1; end
        else begin r = a + b; ok = !is_reg || f7 == 7'h00; end
      end
      3'd1: begin r = a << b[4:0]; ok = (f7 == 7'h00); end
      3'd2: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; ok = !is_reg || f7 == 7'h00; end
      3'd3: begin r = (a < b) ? 32'd1 : 32'd0; ok = !is_reg || f7 == 7'h00; end
      3'd4: begin r = a ^ b; ok = !is_reg || f7 == 7'h00; end
      3'd5: begin
        if (f7 == 7'h20) begin r = $unsigned($signed(a) >>> b[4:0]); ok = 1'b1; end
        else begin r = a >> b[4:0]; ok = (f7 == 7'h00); end
      end
      3'd6: begin r = a | b; ok = !is_reg || f7 == 7'h00; end
      default: begin r = a & b; ok = !is_reg || f7 == 7'h00; end
    endcase
    return ok ? {1'b1, r} : {1'b0, prev};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one cycle, push the expectation, sample #1 after the edge.
  task automatic step_cycle(input string tag, input logic en, input logic [31:0] ins,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [32:0] exp);
    logic [32:0] e;
    enable = en;
    instr  = ins;
    op1    = a;
    op2    = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".exec"}, {31'b0, instr_exec}, {31'b0, e[32]});
    check_eq({tag, ".res"}, result, e[31:0]);
    if (e[32]) last_res = e[31:0];
  endtask

  task automatic drive_exp(input string tag, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input logic exp_exec, input logic [31:0] exp_res);
    step_cycle(tag, 1'b1, ins, a, b, {exp_exec, exp_res});
  endtask

  task automatic drive_model(input string tag, input logic en, input logic [31:0] ins,
                             input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    m = en ? model(ins, a, b, last_res) : {1'b0, last_res};
    step_cycle(tag, en, ins, a, b, m);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0]  f7_tab [3];
    logic [6:0]  opc_tab[5];
    logic [31:0] ins;
    logic [6:0]  f7;
    n_checks = 0;
    n_errors = 0;
    last_res = 32'h0;
    f7_tab  = '{7'h00, 7'h20, 7'h01};
    opc_tab = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011};

    // Reset held with a valid ADD presented: outputs stay clear.
    rst    = 1'b0;
    enable = 1'b1;
    instr  = enc_r(7'h00, 3'b000);
    op1    = 32'h0000_0003;
    op2    = 32'h0000_0004;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold.exec", {31'b0, instr_exec}, 32'h0);
    check_eq("rst_hold.res", result, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ADD / SUB wrap
    drive_exp("add_wrap", enc_r(7'h00, 3'b000), 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0);
    drive_exp("sub_wrap", enc_r(7'h20, 3'b000), 32'h0, 32'h1, 1'b1, 32'hFFFF_FFFF);

    // Compare / shift
    drive_exp("slt", enc_r(7'h00, 3'b010), 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h1);
    drive_exp("sltu", enc_r(7'h00, 3'b011), 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0);
    drive_exp("sra", enc_r(7'h20, 3'b101), 32'h8000_0000, 32'h24, 1'b1, 32'hF800_0000);
    drive_exp("srl", enc_r(7'h00, 3'b101), 32'h8000_0000, 32'h24, 1'b1, 32'h0800_0000);
    drive_exp("sll", enc_r(7'h00, 3'b001), 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);

    // Immediates
    drive_exp("addi", enc_i(12'hFFF, 3'b000), 32'h5, 32'hDEAD_BEEF, 1'b1, 32'h4);
    drive_exp("sltiu", enc_i(12'hFFF, 3'b011), 32'h7, 32'h0, 1'b1, 32'h1);
    drive_exp("srai", enc_i({7'h20, 5'd8}, 3'b101), 32'h8000_0000, 32'h0, 1'b1, 32'hFF80_0000);
    drive_exp("lui", enc_u(20'h12345, 7'b0110111), 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 32'h1234_5000);
    drive_exp("auipc", enc_u(20'h12345, 7'b0010111), 32'h100, 32'hFFFF_FFFF, 1'b1, 32'h1234_5100);

    // Invalid / idle: result must hold 32'h1234_5100
    step_cycle("idle", 1'b0, enc_r(7'h00, 3'b000), 32'h1, 32'h1, {1'b0, 32'h1234_5100});
    drive_exp("load", {12'h004, 5'd1, 3'b010, 5'd3, 7'b0000011}, 32'h1, 32'h1, 1'b0, 32'h1234_5100);
    drive_exp("op_f7_01", enc_r(7'h01, 3'b000), 32'h2, 32'h3, 1'b0, 32'h1234_5100);
    drive_exp("slli_bad", enc_i({7'h20, 5'd1}, 3'b001), 32'h2, 32'h3, 1'b0, 32'h1234_5100);

    // Back-to-back logic ops with enable held high
    drive_exp("b2b_and", enc_r(7'h00, 3'b111), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000);
    drive_exp("b2b_or", enc_r(7'h00, 3'b110), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hFFF0_FFF0);
    drive_exp("b2b_xor", enc_r(7'h00, 3'b100), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0FF0_0FF0);

    // Random instructions checked against the reference model
    for (int i = 0; i < 60; i++) begin
      f7  = f7_tab[$urandom_range(0, 2)];
      ins = $urandom;
      ins[6:0] = opc_tab[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) != 0) ins[31:25] = f7;
      drive_model("rand", ($urandom_range(0, 7) != 0), ins, $urandom, $urandom);
    end

    // Asynchronous reset mid-stream: clears without a clock edge
    drive_exp("pre_rst", enc_r(7'h00, 3'b000), 32'h10, 32'h20, 1'b1, 32'h30);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst.exec", {31'b0, instr_exec}, 32'h0);
    check_eq("async_rst.res", result, 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_low_edge.exec", {31'b0, instr_exec}, 32'h0);
    check_eq("rst_low_edge.res", result, 32'h0);
    last_res = 32'h0;
    @(negedge clk);
    rst = 1'b1;

    // No stale value after reset: an unsupported op must present zero
    drive_exp("post_rst_hold", enc_r(7'h01, 3'b000), 32'h1, 32'h1, 1'b0, 32'h0);
    drive_exp("post_rst_add", enc_r(7'h00, 3'b000), 32'h7, 32'h8, 1'b1, 32'hF);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
